// File: rtl/router_terminal_tx.sv
// router_terminal_tx: terminal-side packet source FIFO feeding one router input port.
// Ports: clk, reset (async active-low); push/data_in from the local producer;
// popin from the router; data_out_i_in/pndng_i_in present the head packet;
// full/count report occupancy; ovf_cnt/self_cnt count dropped pushes (saturating);
// tx_cnt counts packets released to the router (wrapping).
module router_terminal_tx #(
  parameter int pckg_sz = 16,
  parameter int fifo_depth = 16,
  parameter logic [7:0] id = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [pckg_sz-1:0]            data_in,
  input  logic                          popin,
  output logic [pckg_sz-1:0]            data_out_i_in,
  output logic                          pndng_i_in,
  output logic                          full,
  output logic [$clog2(fifo_depth):0]   count,
  output logic [15:0]                   ovf_cnt,
  output logic [15:0]                   self_cnt,
  output logic [15:0]                   tx_cnt
);
  localparam int aw = $clog2(fifo_depth);
  logic [pckg_sz-1:0] mem [fifo_depth];
  logic [aw-1:0] rd_ptr, wr_ptr;
  logic self_hit, do_pop, do_push;
  // A packet addressed to ourselves is dropped, unless our id is the broadcast id.
  always_comb begin
    self_hit = data_in[pckg_sz-1 -: 8] == id && id != broadcast;
    do_pop = popin && pndng_i_in;
    do_push = push && !self_hit && (!full || do_pop);
  end
  assign pndng_i_in = count != '0;
  assign full = count == (aw+1)'(fifo_depth);
  assign data_out_i_in = pndng_i_in ? mem[rd_ptr] : '0;
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      ovf_cnt <= '0;
      self_cnt <= '0;
      tx_cnt <= '0;
    end else begin
      rd_ptr <= rd_ptr + aw'(do_pop);
      wr_ptr <= wr_ptr + aw'(do_push);
      count <= count + (aw+1)'(do_push) - (aw+1)'(do_pop);
      tx_cnt <= tx_cnt + 16'(do_pop);
      if (push && self_hit && self_cnt != '1) self_cnt <= self_cnt + 16'd1;
      if (push && !self_hit && !do_push && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 16'd1;
    end
endmodule

// File: tb/tb_router_terminal_tx.sv
// tb_router_terminal_tx: vector table plus scoreboard checks of router_terminal_tx.
module tb_router_terminal_tx;
  logic clk = 0, reset = 0, push = 0, popin = 0, push5 = 0, popin5 = 0;
  logic [15:0] data_in = '0;
  logic [15:0] dout, dout5, ovf, selfc, tx, ovf5, self5, tx5;
  logic pnd, pnd5, full, full5;
  logic [4:0] count, count5;
  int n_chk = 0, n_fail = 0;
  int m_ovf = 0, m_self = 0, m_tx = 0;
  logic [15:0] sb[$];
  typedef struct {
    logic sel5;
    logic p;
    logic [15:0] d;
    logic po;
    logic e_pnd;
    logic [15:0] e_dout;
    logic [4:0] e_cnt;
    logic [15:0] e_self;
    logic [15:0] e_tx;
  } vec_t;
  vec_t tbl[11];
  always #5 clk = ~clk;
  router_terminal_tx u0 (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .popin(popin),
    .data_out_i_in(dout), .pndng_i_in(pnd), .full(full), .count(count),
    .ovf_cnt(ovf), .self_cnt(selfc), .tx_cnt(tx)
  );
  router_terminal_tx #(.id(8'd5)) u5 (
    .clk(clk), .reset(reset), .push(push5), .data_in(data_in), .popin(popin5),
    .data_out_i_in(dout5), .pndng_i_in(pnd5), .full(full5), .count(count5),
    .ovf_cnt(ovf5), .self_cnt(self5), .tx_cnt(tx5)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // One clock of stimulus on u0; the scoreboard decides acceptance from its own occupancy.
  task automatic cyc(input logic p, input logic [15:0] d, input logic po);
    logic acc_pop, acc_push;
    push = p; data_in = d; popin = po;
    acc_pop = po && sb.size() != 0;
    if (acc_pop) chk("head", {16'd0, dout}, {16'd0, sb[0]});
    acc_push = p && d[15:8] != 8'd0 && (sb.size() < 16 || acc_pop);
    if (p && d[15:8] == 8'd0) m_self++;
    else if (p && !acc_push) m_ovf++;
    if (acc_pop) begin
      void'(sb.pop_front());
      m_tx++;
    end
    if (acc_push) sb.push_back(d);
    @(posedge clk); #1;
    push = 0; popin = 0;
    chk("pndng", {31'd0, pnd}, {31'd0, sb.size() != 0});
    chk("count", {27'd0, count}, sb.size());
    chk("full", {31'd0, full}, {31'd0, sb.size() == 16});
    chk("ovf_cnt", {16'd0, ovf}, m_ovf);
    chk("self_cnt", {16'd0, selfc}, m_self);
    chk("tx_cnt", {16'd0, tx}, m_tx);
    chk("dout", {16'd0, dout}, sb.size() != 0 ? {16'd0, sb[0]} : 32'd0);
  endtask
  // Reset asserted between edges must clear the visible state before the next edge.
  task automatic async_rst();
    #2 reset = 0;
    #1;
    chk("rst_pndng", {31'd0, pnd}, 0);
    chk("rst_count", {27'd0, count}, 0);
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_dout", {16'd0, dout}, 0);
    chk("rst_cnts", {ovf | selfc, tx}, 0);
    #1 reset = 1;
    sb.delete();
    m_ovf = 0; m_self = 0; m_tx = 0;
  endtask
  initial begin
    logic [15:0] r;
    tbl[0]  = '{1'b0, 1'b1, 16'h2A55, 1'b0, 1'b1, 16'h2A55, 5'd1, 16'd0, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 5'd0, 16'd0, 16'd1};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 5'd0, 16'd0, 16'd1};
    tbl[3]  = '{1'b1, 1'b1, 16'h0577, 1'b0, 1'b0, 16'h0000, 5'd0, 16'd1, 16'd0};
    tbl[4]  = '{1'b1, 1'b1, 16'hFF77, 1'b0, 1'b1, 16'hFF77, 5'd1, 16'd1, 16'd0};
    tbl[5]  = '{1'b1, 1'b1, 16'h0078, 1'b0, 1'b1, 16'hFF77, 5'd2, 16'd1, 16'd0};
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0078, 5'd1, 16'd1, 16'd1};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 5'd0, 16'd1, 16'd2};
    tbl[8]  = '{1'b0, 1'b1, 16'h0C0C, 1'b1, 1'b1, 16'h0C0C, 5'd1, 16'd0, 16'd1};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 5'd0, 16'd0, 16'd2};
    tbl[10] = '{1'b0, 1'b1, 16'h0033, 1'b0, 1'b0, 16'h0000, 5'd0, 16'd1, 16'd2};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pndng", {31'd0, pnd}, 0);
    chk("reset_count", {27'd0, count}, 0);
    chk("reset_dout", {16'd0, dout}, 0);
    chk("reset_cnts", {ovf | selfc, tx}, 0);
    reset = 1;
    foreach (tbl[i]) begin
      data_in = tbl[i].d;
      push = tbl[i].p && !tbl[i].sel5;
      popin = tbl[i].po && !tbl[i].sel5;
      push5 = tbl[i].p && tbl[i].sel5;
      popin5 = tbl[i].po && tbl[i].sel5;
      @(posedge clk); #1;
      push = 0; popin = 0; push5 = 0; popin5 = 0;
      chk($sformatf("vec%0d_pndng", i), {31'd0, tbl[i].sel5 ? pnd5 : pnd}, {31'd0, tbl[i].e_pnd});
      chk($sformatf("vec%0d_dout", i), {16'd0, tbl[i].sel5 ? dout5 : dout}, {16'd0, tbl[i].e_dout});
      chk($sformatf("vec%0d_count", i), {27'd0, tbl[i].sel5 ? count5 : count}, {27'd0, tbl[i].e_cnt});
      chk($sformatf("vec%0d_self", i), {16'd0, tbl[i].sel5 ? self5 : selfc}, {16'd0, tbl[i].e_self});
      chk($sformatf("vec%0d_tx", i), {16'd0, tbl[i].sel5 ? tx5 : tx}, {16'd0, tbl[i].e_tx});
    end
    async_rst();
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) cyc(1'b1, 16'h0100 + 16'(i), 1'b0);
    for (int i = 0; i < 17; i++) cyc(1'b0, 16'h0000, 1'b1);
    async_rst();
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) cyc(1'b1, 16'h0200 + 16'(i), 1'b0);
    cyc(1'b1, 16'h0311, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 16'h0000, 1'b1);
    async_rst();
    @(posedge clk); #1;
    repeat (3) cyc(1'b0, 16'h0000, 1'b1);
    cyc(1'b1, 16'h0A0A, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h0C00 + 16'(i), 1'b0);
    async_rst();
    @(posedge clk); #1;
    cyc(1'b1, 16'h0B0B, 1'b0);
    for (int i = 0; i < 40; i++) begin
      r = 16'($urandom);
      if (r[15:8] == 8'd0) r[15:8] = 8'h11;
      cyc(1'b1, r, 1'b1);
    end
    repeat (2) cyc(1'b0, 16'h0000, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
